// File: rtl/mod_down_timer_4_bit.sv
// Programmable MOD-N down-counting timer with terminal pulse, sticky expiry and optional
// auto-reload. State advances on the falling edge of Clk_In.
module mod_down_timer_4_bit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             Clk_In,
    input  logic             Reset_In,
    input  logic             Load_In,
    input  logic             Start_Stopb_In,
    input  logic             Auto_Reload_In,
    input  logic             Clear_Expired_In,
    input  logic [WIDTH-1:0] MOD_Value_In,
    output logic [WIDTH-1:0] Count_Out,
    output logic             Terminal_Count_Out,
    output logic             Busy_Out,
    output logic             Expired_Out
);

    localparam logic [WIDTH-1:0] OneVal = WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StRun, StHold, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             expired_q, expired_d;
    logic             active;
    logic             terminal;

    assign active   = (state_q == StRun) || (state_q == StHold);
    // A load on the same edge pre-empts any count or terminal activity.
    assign terminal = !Load_In && active && Start_Stopb_In && (count_q == '0);

    always_ff @(negedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q   <= StIdle;
            count_q   <= '0;
            reload_q  <= '0;
            tc_q      <= 1'b0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            tc_q      <= tc_d;
            busy_q    <= busy_d;
            expired_q <= expired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (Load_In) begin
            state_d = StHold;
        end else if (active) begin
            if (!Start_Stopb_In) begin
                state_d = StHold;
            end else if (count_q != '0) begin
                state_d = StRun;
            end else begin
                state_d = Auto_Reload_In ? StRun : StDone;
            end
        end
    end

    always_comb begin
        count_d   = count_q;
        reload_d  = reload_q;
        tc_d      = terminal;
        expired_d = expired_q;
        busy_d    = (state_d == StRun);
        if (Load_In) begin
            // N = 0 wraps to all-ones, giving a full 2^WIDTH period.
            reload_d  = MOD_Value_In - OneVal;
            count_d   = MOD_Value_In - OneVal;
            expired_d = 1'b0;
        end else begin
            if (active && Start_Stopb_In) begin
                if (count_q != '0) begin
                    count_d = count_q - OneVal;
                end else if (Auto_Reload_In) begin
                    count_d = reload_q;
                end
            end
            if (terminal) begin
                expired_d = 1'b1;
            end else if (Clear_Expired_In) begin
                expired_d = 1'b0;
            end
        end
    end

    assign Count_Out          = count_q;
    assign Terminal_Count_Out = tc_q;
    assign Busy_Out           = busy_q;
    assign Expired_Out        = expired_q;

endmodule

// File: tb/tb_mod_down_timer_4_bit.sv
// Directed self-checking bench for mod_down_timer_4_bit; inputs change and outputs are
// sampled 1 time unit after each falling edge.
module tb_mod_down_timer_4_bit;

    logic       clk;
    logic       reset;
    logic       load;
    logic       start;
    logic       auto_rl;
    logic       clr;
    logic [3:0] mod_val;
    logic [3:0] count;
    logic       tc;
    logic       busy;
    logic       expired;

    int errors = 0;
    int checks = 0;

    mod_down_timer_4_bit #(.WIDTH(4)) dut (
        .Clk_In             (clk),
        .Reset_In           (reset),
        .Load_In            (load),
        .Start_Stopb_In     (start),
        .Auto_Reload_In     (auto_rl),
        .Clear_Expired_In   (clr),
        .MOD_Value_In       (mod_val),
        .Count_Out          (count),
        .Terminal_Count_Out (tc),
        .Busy_Out           (busy),
        .Expired_Out        (expired)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; start = 1'b0; auto_rl = 1'b0; clr = 1'b0; mod_val = 4'd0;
        tick();
        tick();
        checks++;
        if (count !== 4'd0 || tc !== 1'b0 || busy !== 1'b0 || expired !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: cnt=%0d tc=%b busy=%b exp=%b, want 0/0/0/0",
                     count, tc, busy, expired);
        end
        reset = 1'b0;
        start = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (count !== 4'd0 || busy !== 1'b0 || tc !== 1'b0) begin
                errors++;
                $display("FAIL idle_ignores_start edge %0d: cnt=%0d busy=%b tc=%b, want 0/0/0",
                         i, count, busy, tc);
            end
        end
    endtask

    task automatic test_auto_reload();
        logic [3:0] exp_cnt [12] = '{4, 3, 2, 1, 0, 4, 3, 2, 1, 0, 4, 3};
        logic       exp_tc  [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        mod_val = 4'd5; auto_rl = 1'b1; start = 1'b1; load = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            load = 1'b0;
            checks++;
            if (count !== exp_cnt[i] || tc !== exp_tc[i]) begin
                errors++;
                $display("FAIL auto_reload edge %0d: cnt=%0d tc=%b, want %0d/%b",
                         i, count, tc, exp_cnt[i], exp_tc[i]);
            end
            checks++;
            if (busy !== (i != 0)) begin
                errors++;
                $display("FAIL auto_reload_busy edge %0d: busy=%b, want %b", i, busy, i != 0);
            end
        end
        checks++;
        if (expired !== 1'b1) begin
            errors++;
            $display("FAIL auto_reload_expired: exp=%b, want 1", expired);
        end
    endtask

    task automatic test_stop_hold();
        logic [3:0] exp_cnt  [8] = '{2, 2, 2, 1, 0, 0, 0, 0};
        logic       exp_busy [8] = '{0, 0, 0, 1, 1, 0, 0, 0};
        logic       exp_tc   [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
        logic       exp_exp  [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
        mod_val = 4'd3; auto_rl = 1'b0; start = 1'b0; load = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            load = 1'b0;
            if (i == 2) start = 1'b1;
            checks++;
            if (count !== exp_cnt[i] || busy !== exp_busy[i] || tc !== exp_tc[i]
                || expired !== exp_exp[i]) begin
                errors++;
                $display("FAIL stop_hold_done edge %0d: cnt=%0d busy=%b tc=%b exp=%b, want %0d/%b/%b/%b",
                         i, count, busy, tc, expired, exp_cnt[i], exp_busy[i], exp_tc[i],
                         exp_exp[i]);
            end
        end
    endtask

    task automatic test_mod_zero();
        mod_val = 4'd0; auto_rl = 1'b1; start = 1'b1; load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (count !== 4'd15) begin
            errors++;
            $display("FAIL mod_zero_load: cnt=%0d, want 15", count);
        end
        for (int i = 1; i <= 15; i++) begin
            tick();
            checks++;
            if (count !== 4'(15 - i) || tc !== 1'b0) begin
                errors++;
                $display("FAIL mod_zero_count edge %0d: cnt=%0d tc=%b, want %0d/0",
                         i, count, tc, 15 - i);
            end
        end
        tick();
        checks++;
        if (tc !== 1'b1 || count !== 4'd15) begin
            errors++;
            $display("FAIL mod_zero_terminal: tc=%b cnt=%0d, want 1/15", tc, count);
        end
    endtask

    task automatic test_clear_expired();
        mod_val = 4'd1; auto_rl = 1'b1; start = 1'b1; clr = 1'b0; load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (count !== 4'd0 || expired !== 1'b0) begin
            errors++;
            $display("FAIL n1_load: cnt=%0d exp=%b, want 0/0", count, expired);
        end
        tick();
        checks++;
        if (tc !== 1'b1 || expired !== 1'b1 || count !== 4'd0) begin
            errors++;
            $display("FAIL n1_first_terminal: tc=%b exp=%b cnt=%0d, want 1/1/0", tc, expired, count);
        end
        clr = 1'b1;
        tick();
        checks++;
        if (tc !== 1'b1 || expired !== 1'b1) begin
            errors++;
            $display("FAIL clear_vs_terminal: tc=%b exp=%b, want 1/1", tc, expired);
        end
        start = 1'b0;
        tick();
        checks++;
        if (tc !== 1'b0 || expired !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_no_terminal: tc=%b exp=%b busy=%b, want 0/0/0", tc, expired, busy);
        end
        clr = 1'b0;
    endtask

    task automatic test_async_reset();
        mod_val = 4'd7; auto_rl = 1'b1; start = 1'b1; load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 1; i <= 7; i++) tick();
        checks++;
        if (count !== 4'd6 || busy !== 1'b1 || tc !== 1'b1 || expired !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_run: cnt=%0d busy=%b tc=%b exp=%b, want 6/1/1/1",
                     count, busy, tc, expired);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (count !== 4'd0 || busy !== 1'b0 || tc !== 1'b0 || expired !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: cnt=%0d busy=%b tc=%b exp=%b, want 0/0/0/0",
                     count, busy, tc, expired);
        end
        #1 reset = 1'b0;
        tick();
        tick();
        checks++;
        if (count !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: cnt=%0d busy=%b, want 0/0", count, busy);
        end
    endtask

    task automatic test_back_to_back();
        mod_val = 4'd2; auto_rl = 1'b1; start = 1'b1; load = 1'b1;
        tick();
        load = 1'b0;
        mod_val = 4'd9;
        checks++;
        if (count !== 4'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL load_no_decrement: cnt=%0d busy=%b, want 1/0", count, busy);
        end
        tick();
        checks++;
        if (count !== 4'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_then_run: cnt=%0d busy=%b, want 0/1", count, busy);
        end
        tick();
        checks++;
        if (count !== 4'd1 || tc !== 1'b1) begin
            errors++;
            $display("FAIL reload_ignores_new_mod: cnt=%0d tc=%b, want 1/1", count, tc);
        end
        // Reload in the middle of a run restarts from the new modulus.
        mod_val = 4'd4; load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (count !== 4'd3 || tc !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reload_mid_run: cnt=%0d tc=%b busy=%b, want 3/0/0", count, tc, busy);
        end
    endtask

    initial begin
        test_reset();
        test_auto_reload();
        test_stop_hold();
        test_mod_zero();
        test_clear_expired();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1);
    end

endmodule

// File: doc/mod_down_timer_4_bit.md
# mod_down_timer_4_bit

Programmable MOD-N down-counting timer. It loads a modulus, counts down from N-1 to 0 while enabled, and flags each terminal count with a one-cycle pulse. At terminal count it either auto-reloads or stops in a sticky expired state. It is the complement of the team's up-counting MOD counter and serves as the countdown and timeout source for control FSMs that need "fire after N enabled cycles" behaviour.

## Interface
- WIDTH, 4, counter and modulus width in bits.
- Clk_In  input  1  clock; all state updates on the falling edge.
- Reset_In  input  1  reset, asynchronous, active-high.
- Load_In  input  1  load strobe; captures MOD_Value_In.
- Start_Stopb_In  input  1  1 = decrement enabled, 0 = hold.
- Auto_Reload_In  input  1  1 = reload at terminal count, 0 = stop.
- Clear_Expired_In  input  1  clears Expired_Out.
- MOD_Value_In  input  WIDTH  modulus N; 0 means 2^WIDTH.
- Count_Out  output  WIDTH  current count.
- Terminal_Count_Out  output  1  one-cycle pulse at each terminal event.
- Busy_Out  output  1  high while in RUN.
- Expired_Out  output  1  sticky terminal flag.

## Operation
- Internal register Reload_Reg[WIDTH] holds the last loaded N-1.
- States:
  - IDLE: nothing loaded.
  - RUN: decrementing.
  - HOLD: loaded, paused.
  - DONE: expired, no reload.
- Reset values:
  - State IDLE.
  - Count_Out = 0, Reload_Reg = 0.
  - Terminal_Count_Out = 0, Busy_Out = 0, Expired_Out = 0.
- Priority per edge: Reset_In > Load_In > count/terminal logic > Clear_Expired_In.
- Load_In = 1, any state:
  - Reload_Reg and Count_Out <= MOD_Value_In - 1, modulo 2^WIDTH, so N = 0 gives all-ones.
  - Expired_Out <= 0.
  - State <= HOLD.
  - No decrement on this edge, whatever Start_Stopb_In is.
- IDLE: Start_Stopb_In is ignored; Count_Out holds 0.
- RUN/HOLD, Start_Stopb_In = 0: Count_Out holds; state <= HOLD.
- RUN/HOLD, Start_Stopb_In = 1, Count_Out != 0: Count_Out <= Count_Out - 1; state <= RUN.
- RUN/HOLD, Start_Stopb_In = 1, Count_Out == 0 (terminal event):
  - Terminal_Count_Out <= 1 for exactly one cycle.
  - Expired_Out <= 1.
  - If Auto_Reload_In = 1: Count_Out <= Reload_Reg; state <= RUN.
  - If Auto_Reload_In = 0: Count_Out stays 0; state <= DONE.
- DONE: Count_Out holds 0; Start_Stopb_In is ignored; exit only via Load_In or Reset_In.
- Clear_Expired_In clears Expired_Out. A terminal event on the same edge wins, so Expired_Out stays 1.
- Busy_Out is registered: it equals (state == RUN).
- No overflow or underflow: the decrement never occurs at 0.

## Timing
- Load at edge 0 with Start_Stopb_In held 1:
  - Count_Out = N-1 after edge 0.
  - Count_Out = 0 after edge N-1.
  - Terminal pulse after edge N.
- Terminal period with auto-reload is N enabled edges. Disabled edges stretch the period 1:1.
- N = 1 with auto-reload and continuous enable: Terminal_Count_Out stays high every cycle; Count_Out stays 0.
- N = 0 (read as 16 at WIDTH = 4): the first terminal pulse comes 16 enabled edges after load.
- Auto_Reload_In is sampled only on the terminal edge.
- MOD_Value_In is sampled only on load edges. A later change does not affect Reload_Reg.
- Reset mid-count: all outputs clear immediately, asynchronously. After release, the timer stays IDLE until Load_In.

## Test plan
- Reset, then assert Start_Stopb_In = 1 without Load_In for 5 edges -> Count_Out = 0, Busy_Out = 0, no Terminal_Count_Out pulse.
- Load N = 5, Auto_Reload_In = 1, Start_Stopb_In = 1 for 12 edges -> Count_Out sequence 4,3,2,1,0,4,3,2,1,0,4,3; Terminal_Count_Out pulses after edges 5 and 10.
- Load N = 3, Auto_Reload_In = 0; hold Start_Stopb_In = 0 for 2 edges, then 1 -> count holds at 2 in HOLD, then 1, 0; terminal event enters DONE with Expired_Out = 1; further Start_Stopb_In has no effect.
- N = 0 load with Start_Stopb_In = 1 -> Count_Out = 15 after load; terminal pulse on the 16th enabled edge.
- Assert Clear_Expired_In on the same edge as a terminal event -> Expired_Out = 1. Assert it on the next edge with no terminal event -> Expired_Out = 0.
- Assert Reset_In asynchronously while Count_Out = 6 in RUN -> all outputs go to 0 immediately without waiting for a clock edge. Load N = 2 on the same edge that Start_Stopb_In = 1 -> Count_Out = 1 with no decrement on that edge.
